restoring_div_ctrl: RTL and testbench
=====================================

RESTORING_DIV_CTRL -- requirements
Module: restoring_div_ctrl

Interface
REQ-001 SHALL take parameter: WIDTH, 64, operand/result width in bits (>=2).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port: dividend  input  WIDTH  unsigned numerator, captured on accepted start.
REQ-006 SHALL have port: divisor  input  WIDTH  unsigned denominator, captured on accepted start.
REQ-007 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port: quotient  output  WIDTH  unsigned quotient.
REQ-010 SHALL have port: remainder  output  WIDTH  unsigned remainder.
REQ-011 SHALL have port: div_by_zero  output  1  divide-by-zero flag, valid with done.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; transitions: IDLE->RUN on start; RUN->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-013 SHALL, on accepted start, latch divisor, load partial remainder R=0, Q=dividend, iteration counter=WIDTH.
REQ-014 SHALL, each RUN cycle: shift {R,Q} left 1; compute trial = R - divisor as R + ~divisor + 1 in WIDTH+1 bits; carry-out 1 (no borrow) -> R=trial, Q[0]=1; else R unchanged, Q[0]=0; decrement counter.
REQ-015 SHALL use one shared WIDTH+1-bit adder/subtractor for every iteration; no second arithmetic unit.
REQ-016 SHALL assert done exactly one cycle, WIDTH+1 cycles after the edge that accepted start.
REQ-017 SHALL drive quotient/remainder from internal Q/R; values final when done is high and held stable until the next accepted start.
REQ-018 SHALL ignore start while busy (RUN or DONE); no queuing, operands unchanged.
REQ-019 SHALL, for divisor 0 without early detection, produce quotient all-ones and remainder = dividend via normal iteration.
REQ-020 SHALL produce correct results at boundaries: dividend < divisor -> q=0, r=dividend; divisor 1 -> q=dividend, r=0; dividend = 2^WIDTH-1.

Reset
REQ-021 SHALL, on rst high at any time, immediately force IDLE, counter 0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-022 SHALL abandon an in-flight operation on reset mid-RUN; no done pulse for it after rst deasserts.
REQ-023 SHALL accept a start on the first rising edge after rst deasserts.

Configuration
REQ-024 SHALL honour macro DIV_ZERO_DETECT_EN.
REQ-025 SHALL, with DIV_ZERO_DETECT_EN defined, on accepted start with divisor 0 go IDLE->DONE directly, set div_by_zero=1, quotient all-ones, remainder=dividend, done one cycle after accept.
REQ-026 SHALL, without DIV_ZERO_DETECT_EN, tie div_by_zero to 0 and process divisor 0 through full WIDTH-iteration RUN (REQ-019).
REQ-027 SHALL clear div_by_zero on the next accepted start in both builds.

Verification
REQ-028 SHALL cover: WIDTH=64, start with 100/7 -> done at cycle 65 after accept, quotient=14, remainder=2, div_by_zero=0.
REQ-029 SHALL cover: 5/9 -> quotient=0, remainder=5; then 0xFFFF_FFFF_FFFF_FFFF/1 -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0.
REQ-030 SHALL cover: 1234/0 with DIV_ZERO_DETECT_EN -> done 1 cycle after accept, div_by_zero=1, quotient all-ones, remainder=1234; without macro -> done at cycle 65, div_by_zero=0, same quotient/remainder.
REQ-031 SHALL cover: start 50/3, then start 9/9 pulsed during RUN -> ignored; single done with quotient=16, remainder=2.
REQ-032 SHALL cover: start 1000/10, rst asserted 10 cycles later -> outputs 0, busy=0 immediately; no done; new start 1000/10 -> quotient=100, remainder=0.

Source files
------------

// File: rtl/restoring_div_ctrl.sv
// restoring_div_ctrl: iterative unsigned restoring divider, one quotient bit per cycle.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor bypasses the iterations and
// flags div_by_zero; without it div_by_zero is tied low and a zero divisor
// simply runs the full loop (quotient all-ones, remainder = dividend).
module restoring_div_ctrl #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH:0] ONE_W1 = {{WIDTH{1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dsr;

    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_sum;
    logic             w_no_borrow;

    // Shifted partial remainder {R, Q msb}; the single subtractor works on its low
    // WIDTH bits. If the shifted-out top bit is set the value already exceeds
    // any divisor, so the subtraction always succeeds and the result fits WIDTH bits.
    always_comb begin
        w_rem_shift = {r_rem, r_quo[WIDTH-1]};
        w_sum       = {1'b0, w_rem_shift[WIDTH-1:0]} + {1'b0, ~r_dsr} + ONE_W1;
        w_no_borrow = w_sum[WIDTH] | w_rem_shift[WIDTH];
    end

`ifdef DIV_ZERO_DETECT_EN
    logic r_dbz;
    assign div_by_zero = r_dbz;
`else
    assign div_by_zero = 1'b0;
`endif

    // Control FSM plus the quotient/remainder datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dsr   <= '0;
`ifdef DIV_ZERO_DETECT_EN
            r_dbz   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
`ifdef DIV_ZERO_DETECT_EN
                        r_dbz <= 1'b0;
                        if (divisor == '0) begin
                            r_state <= DONE;
                            r_dsr   <= divisor;
                            r_quo   <= '1;
                            r_rem   <= dividend;
                            r_cnt   <= '0;
                            r_dbz   <= 1'b1;
                        end else
`endif
                        begin
                            r_state <= RUN;
                            r_dsr   <= divisor;
                            r_rem   <= '0;
                            r_quo   <= dividend;
                            r_cnt   <= CNT_W'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_no_borrow ? w_sum[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_no_borrow};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Status and result outputs come straight from state and datapath registers.
    always_comb begin
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
        quotient  = r_quo;
        remainder = r_rem;
    end

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// tb_restoring_div_ctrl: directed and random checks of restoring_div_ctrl against
// a plain-arithmetic division model. Expectations follow DIV_ZERO_DETECT_EN.
module tb_restoring_div_ctrl;

    localparam int unsigned W = 64;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_asserts;
    int n_fail;

    restoring_div_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: quotient/remainder, zero-divisor behaviour and latency.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dbz, output int lat);
        if (b == 0) begin
            q = {W{1'b1}};
            r = a;
`ifdef DIV_ZERO_DETECT_EN
            dbz = 1'b1;
            lat = 1;
`else
            dbz = 1'b0;
            lat = W + 1;
`endif
        end else begin
            q   = a / b;
            r   = a % b;
            dbz = 1'b0;
            lat = W + 1;
        end
    endtask

    // Drive a request and let the next rising edge accept it.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    // Wait for done (bounded), then check latency, results, pulse width and hold.
    task automatic finish_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int c0);
        logic [W-1:0] eq, er;
        logic         edbz;
        int           elat;
        int           c;
        model(a, b, eq, er, edbz, elat);
        c = c0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < 300);
        chk({tag, "_latency"}, W'(c), W'(elat));
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, edbz});
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {62'd0, done, busy}, 64'd0);
        repeat (2) @(negedge clk);
        chk({tag, "_q_hold"}, quotient, eq);
        chk({tag, "_r_hold"}, remainder, er);
    endtask

    initial begin
        logic [W-1:0] a, b;
        int           done_seen;
        n_asserts = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;

        // Reset state
        #1;
        chk("reset_outputs", {60'd0, busy, done, div_by_zero, 1'b0}, 64'd0);
        chk("reset_quotient", quotient, 64'd0);
        chk("reset_remainder", remainder, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases
        start_op(64'd100, 64'd7);
        finish_op("d100_7", 64'd100, 64'd7, 0);
        start_op(64'd5, 64'd9);
        finish_op("d5_9", 64'd5, 64'd9, 0);
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        finish_op("dmax_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
        start_op(64'd1234, 64'd0);
        finish_op("d1234_0", 64'd1234, 64'd0, 0);
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001);
        finish_op("dmax_big", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 0);
        // A normal op after a zero-divisor op must clear the flag
        start_op(64'd77, 64'd7);
        finish_op("d77_7_clear", 64'd77, 64'd7, 0);

        // Start pulsed during RUN with different operands is ignored
        start_op(64'd50, 64'd3);
        @(negedge clk);
        dividend = 64'd9;
        divisor  = 64'd9;
        start    = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        finish_op("ignore_start", 64'd50, 64'd3, 4);

        // Reset mid-RUN abandons the operation
        start_op(64'd1000, 64'd10);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        chk("midrun_rst_quotient", quotient, 64'd0);
        chk("midrun_rst_remainder", remainder, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk("no_done_after_rst", W'(done_seen), 64'd0);

        // Start accepted on the first edge after reset release
        @(negedge clk);
        rst      = 1'b1;
        dividend = 64'd1000;
        divisor  = 64'd10;
        start    = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        chk("first_edge_accept", {63'd0, busy}, 64'd1);
        finish_op("d1000_10", 64'd1000, 64'd10, 0);

        // Random operands against the arithmetic model
        for (int i = 0; i < 12; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (i == 5) b = 64'd0;
            if (i == 7) a = a >> 40;
            start_op(a, b);
            finish_op("random", a, b, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
